// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: FSM state encoding, S-box size, the printable-text
// acceptance range and the key byte selector.
package rc4_pkg;

  localparam int unsigned S_SIZE = 256;

  localparam logic [7:0] ASCII_LO = 8'h61;
  localparam logic [7:0] ASCII_HI = 8'h7A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [4:0] {
    StIdle,
    StInit,
    StKsaRdI,
    StKsaWtI,
    StKsaJ,
    StKsaRdJ,
    StKsaWtJ,
    StKsaSwI,
    StKsaSwJ,
    StPrgaRdI,
    StPrgaWtI,
    StPrgaJ,
    StPrgaRdJ,
    StPrgaWtJ,
    StPrgaSwI,
    StPrgaSwJ,
    StPrgaRdF,
    StPrgaWtF,
    StPrgaWr,
    StDone
  } rc4_state_e;

  // Byte 0 is the most significant of the nbytes-wide key held in the low bits.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input int unsigned idx,
                                          input int unsigned nbytes = 3);
    logic [23:0] sh;
    sh = key >> (8 * (nbytes - 1 - idx));
    return sh[7:0];
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return ((c >= ASCII_LO) && (c <= ASCII_HI)) || (c == ASCII_SP);
  endfunction

endpackage

// File: rtl/rc4_encrypt_core.sv
// RC4 encryptor: KSA + PRGA over an external S RAM, ciphertext written to a result RAM.
// Optional plaintext acceptance flag enabled by defining RC4_PRINTABLE_CHECK_EN.
module rc4_encrypt_core
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN   = 32,
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic        inclk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] secret_key,
  output logic        busy,
  output logic        done,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wdata,
  output logic        s_wren,
  input  logic [7:0]  s_rdata,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rdata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wdata,
  output logic        ct_wren,
  output logic        flag_nonprint
);

  localparam logic [7:0] LastK = 8'(MSG_LEN - 1);
  localparam logic [7:0] LastI = 8'(S_SIZE - 1);

  rc4_state_e  state_q, state_d;
  logic [7:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0]  si_q, si_d, sj_q, sj_d;
  logic [23:0] key_q, key_d;
  logic [7:0]  kbyte;
  logic [7:0]  f_addr;

  assign kbyte  = key_byte(key_q, 32'(i_q) % KEY_BYTES, KEY_BYTES);
  assign f_addr = si_q + sj_q;
  assign busy   = (state_q != StIdle) && (state_q != StDone);

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
    end
  end

  // Read addresses are held through the wait state so s_rdata is stable when captured.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    si_d     = si_q;
    sj_d     = sj_q;
    key_d    = key_q;
    done     = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wren   = 1'b0;
    pt_addr  = '0;
    ct_addr  = '0;
    ct_wdata = '0;
    ct_wren  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          key_d   = secret_key;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = StInit;
        end
      end
      StInit: begin
        s_addr  = i_q;
        s_wdata = i_q;
        s_wren  = 1'b1;
        i_d     = i_q + 8'd1;
        if (i_q == LastI) state_d = StKsaRdI;
      end
      StKsaRdI: begin
        s_addr  = i_q;
        state_d = StKsaWtI;
      end
      StKsaWtI: begin
        s_addr  = i_q;
        state_d = StKsaJ;
      end
      StKsaJ: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata + kbyte;
        state_d = StKsaRdJ;
      end
      StKsaRdJ: begin
        s_addr  = j_q;
        state_d = StKsaWtJ;
      end
      StKsaWtJ: begin
        s_addr  = j_q;
        state_d = StKsaSwI;
      end
      StKsaSwI: begin
        s_addr  = i_q;
        s_wdata = s_rdata;
        s_wren  = 1'b1;
        state_d = StKsaSwJ;
      end
      StKsaSwJ: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
        i_d     = i_q + 8'd1;
        state_d = StKsaRdI;
        if (i_q == LastI) begin
          // i/j cleared and the first PRGA increment folded in.
          i_d     = 8'd1;
          j_d     = '0;
          state_d = StPrgaRdI;
        end
      end
      StPrgaRdI: begin
        s_addr  = i_q;
        state_d = StPrgaWtI;
      end
      StPrgaWtI: begin
        s_addr  = i_q;
        state_d = StPrgaJ;
      end
      StPrgaJ: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata;
        state_d = StPrgaRdJ;
      end
      StPrgaRdJ: begin
        s_addr  = j_q;
        state_d = StPrgaWtJ;
      end
      StPrgaWtJ: begin
        s_addr  = j_q;
        state_d = StPrgaSwI;
      end
      StPrgaSwI: begin
        sj_d    = s_rdata;
        s_addr  = i_q;
        s_wdata = s_rdata;
        s_wren  = 1'b1;
        state_d = StPrgaSwJ;
      end
      StPrgaSwJ: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
        state_d = StPrgaRdF;
      end
      StPrgaRdF: begin
        s_addr  = f_addr;
        pt_addr = k_q;
        state_d = StPrgaWtF;
      end
      StPrgaWtF: begin
        s_addr  = f_addr;
        pt_addr = k_q;
        state_d = StPrgaWr;
      end
      StPrgaWr: begin
        ct_addr  = k_q;
        ct_wdata = s_rdata ^ pt_rdata;
        ct_wren  = 1'b1;
        k_d      = k_q + 8'd1;
        i_d      = i_q + 8'd1;
        state_d  = (k_q == LastK) ? StDone : StPrgaRdI;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef RC4_PRINTABLE_CHECK_EN
  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    if ((state_q == StIdle) && start) begin
      flag_d = 1'b0;
    end else if ((state_q == StPrgaWr) && !is_printable(pt_rdata)) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) flag_q <= 1'b0;
    else          flag_q <= flag_d;
  end

  assign flag_nonprint = flag_q;
`else
  assign flag_nonprint = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_encrypt_core.sv
// Directed bench for rc4_encrypt_core with behavioural S RAM, plaintext ROM and ciphertext RAM.
module tb_rc4_encrypt_core;

  localparam int unsigned MSG_LEN = 10;
`ifdef RC4_PRINTABLE_CHECK_EN
  localparam bit FlagEn = 1'b1;
`else
  localparam bit FlagEn = 1'b0;
`endif

  logic        inclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] secret_key = '0;
  logic        busy, done, s_wren, ct_wren, flag_nonprint;
  logic [7:0]  s_addr, s_wdata, pt_addr, ct_addr, ct_wdata;
  logic [7:0]  s_rdata, pt_rdata;

  logic [7:0] s_mem  [256];
  logic [7:0] pt_rom [256];
  logic [7:0] ct_mem [256];
  int         ct_run [256];
  int         run_id = 0;
  int         ct_cnt = 0;
  int         done_cnt = 0;
  int         both_cnt = 0;

  int n_vec = 0;
  int n_miss = 0;

  logic [7:0] exp_pt [10] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9,
                              8'h40, 8'hAF, 8'h0A, 8'hD3, 8'h19};
  logic [7:0] exp_ks [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                              8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};

  rc4_encrypt_core #(
    .MSG_LEN  (MSG_LEN),
    .KEY_BYTES(3)
  ) dut (
    .inclk        (inclk),
    .reset_n      (reset_n),
    .start        (start),
    .secret_key   (secret_key),
    .busy         (busy),
    .done         (done),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_wren       (s_wren),
    .s_rdata      (s_rdata),
    .pt_addr      (pt_addr),
    .pt_rdata     (pt_rdata),
    .ct_addr      (ct_addr),
    .ct_wdata     (ct_wdata),
    .ct_wren      (ct_wren),
    .flag_nonprint(flag_nonprint)
  );

  always #5 inclk = ~inclk;

  always @(posedge inclk) begin
    if (s_wren) s_mem[s_addr] <= s_wdata;
    s_rdata  <= s_mem[s_addr];
    pt_rdata <= pt_rom[pt_addr];
    if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wdata;
      ct_run[ct_addr] <= run_id;
      ct_cnt          <= ct_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (s_wren && ct_wren) both_cnt <= both_cnt + 1;
  end

  task automatic load_pt(input string s, input logic [7:0] pad);
    for (int n = 0; n < 256; n++) pt_rom[n] = (n < s.len()) ? s[n] : pad;
  endtask

  task automatic pulse_start(input logic [23:0] key);
    @(negedge inclk);
    secret_key = key;
    start      = 1'b1;
    @(negedge inclk);
    start      = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge inclk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge inclk);
    n_vec++;
    if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++;
    if (done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++;
    if ({s_wren, ct_wren} !== 2'b00) begin
      n_miss++; $display("FAIL reset_wren: got %b want 00", {s_wren, ct_wren});
    end
    n_vec++;
    if ({s_addr, pt_addr, ct_addr, s_wdata, ct_wdata} !== 40'h0) begin
      n_miss++; $display("FAIL reset_addr: got %h want 0", {s_addr, pt_addr, ct_addr, s_wdata, ct_wdata});
    end
    n_vec++;
    if (flag_nonprint !== 1'b0) begin n_miss++; $display("FAIL reset_flag: got %b want 0", flag_nonprint); end
    reset_n = 1'b1;
  endtask

  task automatic test_plaintext();
    int d0, c0, b0;
    bit ok;
    load_pt("Plaintext", 8'h00);
    run_id++;
    d0 = done_cnt; c0 = ct_cnt; b0 = both_cnt;
    pulse_start(24'h4B6579);
    n_vec++;
    if (busy !== 1'b1) begin n_miss++; $display("FAIL pt_busy_run: got %b want 1", busy); end
    wait_done(ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL pt_done_timeout: got no done want done"); end
    @(negedge inclk);
    n_vec++;
    if (busy !== 1'b0) begin n_miss++; $display("FAIL pt_busy_after: got %b want 0", busy); end
    for (int n = 0; n < 10; n++) begin
      n_vec++;
      if (ct_mem[n] !== exp_pt[n] || ct_run[n] != run_id) begin
        n_miss++; $display("FAIL pt_ct[%0d]: got %h want %h", n, ct_mem[n], exp_pt[n]);
      end
    end
    n_vec++;
    if (done_cnt - d0 != 1) begin n_miss++; $display("FAIL pt_done_count: got %0d want 1", done_cnt - d0); end
    n_vec++;
    if (ct_cnt - c0 != MSG_LEN) begin
      n_miss++; $display("FAIL pt_ct_writes: got %0d want %0d", ct_cnt - c0, MSG_LEN);
    end
    n_vec++;
    if (both_cnt != b0) begin n_miss++; $display("FAIL pt_wren_overlap: got %0d want 0", both_cnt - b0); end
  endtask

  task automatic test_keystream();
    bit ok;
    load_pt("", 8'h00);
    run_id++;
    pulse_start(24'h4B6579);
    wait_done(ok);
    @(negedge inclk);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL ks_done_timeout: got no done want done"); end
    for (int n = 0; n < 10; n++) begin
      n_vec++;
      if (ct_mem[n] !== exp_ks[n] || ct_run[n] != run_id) begin
        n_miss++; $display("FAIL ks_ct[%0d]: got %h want %h", n, ct_mem[n], exp_ks[n]);
      end
    end
  endtask

  task automatic test_init_determinism();
    logic [7:0] first [10];
    bit ok;
    int cnt, bad;
    load_pt("determinism", 8'h2E);
    run_id++;
    pulse_start(24'h000000);
    wait_done(ok);
    @(negedge inclk);
    for (int n = 0; n < 10; n++) first[n] = ct_mem[n];
    run_id++;
    pulse_start(24'h000000);
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      if (s_wren) cnt++;
      if (cnt == 256) break;
      @(negedge inclk);
    end
    @(negedge inclk);
    n_vec++;
    if (cnt != 256) begin n_miss++; $display("FAIL init_writes: got %0d want 256", cnt); end
    bad = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== 8'(n)) bad++;
    n_vec++;
    if (bad != 0) begin n_miss++; $display("FAIL init_identity: got %0d bad entries want 0", bad); end
    wait_done(ok);
    @(negedge inclk);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL det_done_timeout: got no done want done"); end
    for (int n = 0; n < 10; n++) begin
      n_vec++;
      if (ct_mem[n] !== first[n] || ct_run[n] != run_id) begin
        n_miss++; $display("FAIL det_ct[%0d]: got %h want %h", n, ct_mem[n], first[n]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int c0;
    bit ok;
    load_pt("Plaintext", 8'h00);
    c0 = ct_cnt;
    pulse_start(24'h4B6579);
    repeat (600) @(negedge inclk);
    reset_n = 1'b0;
    @(negedge inclk);
    n_vec++;
    if ({busy, s_wren, ct_wren} !== 3'b000) begin
      n_miss++; $display("FAIL rst_mid_outputs: got %b want 000", {busy, s_wren, ct_wren});
    end
    repeat (2) @(negedge inclk);
    reset_n = 1'b1;
    repeat (3) @(negedge inclk);
    n_vec++;
    if (busy !== 1'b0 || ct_cnt != c0) begin
      n_miss++; $display("FAIL rst_mid_quiet: got busy %b ct writes %0d want 0 0", busy, ct_cnt - c0);
    end
    run_id++;
    pulse_start(24'h4B6579);
    wait_done(ok);
    @(negedge inclk);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL rst_mid_timeout: got no done want done"); end
    for (int n = 0; n < 10; n++) begin
      n_vec++;
      if (ct_mem[n] !== exp_pt[n] || ct_run[n] != run_id) begin
        n_miss++; $display("FAIL rst_mid_ct[%0d]: got %h want %h", n, ct_mem[n], exp_pt[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int d0, c0, b0;
    bit ok;
    load_pt("Plaintext", 8'h00);
    run_id++;
    d0 = done_cnt; c0 = ct_cnt; b0 = both_cnt;
    pulse_start(24'h4B6579);
    repeat (100) @(negedge inclk);
    secret_key = 24'h000000;
    start = 1'b1;
    @(negedge inclk);
    start = 1'b0;
    repeat (1500) @(negedge inclk);
    start = 1'b1;
    @(negedge inclk);
    start = 1'b0;
    wait_done(ok);
    start = 1'b1;
    @(negedge inclk);
    start = 1'b0;
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL b2b_timeout: got no done want done"); end
    n_vec++;
    if (busy !== 1'b0) begin n_miss++; $display("FAIL b2b_done_start: got busy %b want 0", busy); end
    repeat (20) @(negedge inclk);
    n_vec++;
    if (done_cnt - d0 != 1) begin n_miss++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt - d0); end
    n_vec++;
    if (ct_cnt - c0 != MSG_LEN) begin
      n_miss++; $display("FAIL b2b_ct_writes: got %0d want %0d", ct_cnt - c0, MSG_LEN);
    end
    n_vec++;
    if (both_cnt != b0) begin n_miss++; $display("FAIL b2b_wren_overlap: got %0d want 0", both_cnt - b0); end
    for (int n = 0; n < 10; n++) begin
      n_vec++;
      if (ct_mem[n] !== exp_pt[n] || ct_run[n] != run_id) begin
        n_miss++; $display("FAIL b2b_ct[%0d]: got %h want %h", n, ct_mem[n], exp_pt[n]);
      end
    end
  endtask

  task automatic test_printable();
    bit ok, seen;
    load_pt("Hello", 8'h20);
    pulse_start(24'h4B6579);
    seen = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (ct_wren) begin
        seen = 1'b1;
        break;
      end
      @(negedge inclk);
    end
    @(negedge inclk);
    n_vec++;
    if (!seen || flag_nonprint !== FlagEn) begin
      n_miss++; $display("FAIL flag_hello_byte0: got %b want %b", flag_nonprint, FlagEn);
    end
    wait_done(ok);
    @(negedge inclk);
    n_vec++;
    if (!ok || flag_nonprint !== FlagEn) begin
      n_miss++; $display("FAIL flag_hello_end: got %b want %b", flag_nonprint, FlagEn);
    end
    load_pt("hello world", 8'h20);
    pulse_start(24'h4B6579);
    n_vec++;
    if (flag_nonprint !== 1'b0) begin
      n_miss++; $display("FAIL flag_clear_on_start: got %b want 0", flag_nonprint);
    end
    wait_done(ok);
    @(negedge inclk);
    n_vec++;
    if (!ok || flag_nonprint !== 1'b0) begin
      n_miss++; $display("FAIL flag_hello_world: got %b want 0", flag_nonprint);
    end
  endtask

  initial begin
    test_reset();
    test_plaintext();
    test_keystream();
    test_init_determinism();
    test_reset_midrun();
    test_back_to_back();
    test_printable();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
